// File: rtl/ccu_chain_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_chain_pipe
//  Purpose  : Pipelined WIDTH-bit add/sub/inc/dec, one carry register per
//             SEG_WIDTH-bit segment, with input skew and output deskew.
//             Optional macro CCU_CHAIN_PIPE_SATURATE_EN clamps DOUT on OVF.
//  Revision : 1.0  initial release
// ============================================================================
module ccu_chain_pipe #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 8   // WIDTH must be a multiple of SEG_WIDTH
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             CE,
    input  logic             VALID_IN,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             COUT,
    output logic             OVF,
    output logic             VALID_OUT
);

    localparam int LATENCY = WIDTH / SEG_WIDTH;

    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_inc = 2'b10;
    localparam logic [1:0] c_op_dec = 2'b11;

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_y0;
    logic             w_c0;

    // Everything reduces to X + Y + c0; subtraction is A + ~B + ~borrow.
    always_comb begin
        w_x0 = A;
        w_y0 = B;
        w_c0 = CIN;
        case (OP)
            c_op_sub: begin
                w_y0 = ~B;
                w_c0 = ~CIN;
            end
            c_op_inc: w_y0 = '0;
            c_op_dec: begin
                w_y0 = '1;
                w_c0 = ~CIN;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        localparam int c_lo  = k * SEG_WIDTH;
        localparam int c_rem = WIDTH - c_lo;

        // Operand bits still to be summed (this segment and above), and the
        // result bits already produced (this segment and below).
        logic [c_rem-1:0]          w_x;
        logic [c_rem-1:0]          w_y;
        logic                      w_c_in;
        logic                      w_v_in;
        logic [SEG_WIDTH-1:0]      w_sum;
        logic                      w_c_out;
        logic [c_lo+SEG_WIDTH-1:0] w_s_acc;

        if (k == 0) begin : g_first
            assign w_x     = w_x0;
            assign w_y     = w_y0;
            assign w_c_in  = w_c0;
            assign w_v_in  = VALID_IN;
            assign w_s_acc = w_sum;
        end else begin : g_next
            assign w_x     = g_stage[k-1].g_reg.r_x;
            assign w_y     = g_stage[k-1].g_reg.r_y;
            assign w_c_in  = g_stage[k-1].g_reg.r_c;
            assign w_v_in  = g_stage[k-1].g_reg.r_v;
            assign w_s_acc = {w_sum, g_stage[k-1].g_reg.r_s};
        end

        assign {w_c_out, w_sum} = {1'b0, w_x[SEG_WIDTH-1:0]}
                                + {1'b0, w_y[SEG_WIDTH-1:0]}
                                + {{SEG_WIDTH{1'b0}}, w_c_in};

        if (k < LATENCY - 1) begin : g_reg
            logic [c_rem-SEG_WIDTH-1:0] r_x;
            logic [c_rem-SEG_WIDTH-1:0] r_y;
            logic [c_lo+SEG_WIDTH-1:0]  r_s;
            logic                       r_c;
            logic                       r_v;

            always_ff @(posedge CLK) begin
                if (LSR) begin
                    r_x <= '0;
                    r_y <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                    r_v <= 1'b0;
                end else if (CE) begin
                    r_x <= w_x[c_rem-1:SEG_WIDTH];
                    r_y <= w_y[c_rem-1:SEG_WIDTH];
                    r_s <= w_s_acc;
                    r_c <= w_c_out;
                    r_v <= w_v_in;
                end
            end
        end else begin : g_out
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            // Same-sign operands with a different-sign result: equivalent to
            // carry-into-MSB XOR carry-out-of-MSB.
            assign w_ovf = (w_x[c_rem-1] == w_y[c_rem-1]) &&
                           (w_sum[SEG_WIDTH-1] != w_x[c_rem-1]);

`ifdef CCU_CHAIN_PIPE_SATURATE_EN
            assign w_res = !w_ovf       ? w_s_acc :
                           w_x[c_rem-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign w_res = w_s_acc;
`endif

            // Result registers load only on valid slots so they hold otherwise.
            always_ff @(posedge CLK) begin
                if (LSR) begin
                    DOUT      <= '0;
                    COUT      <= 1'b0;
                    OVF       <= 1'b0;
                    VALID_OUT <= 1'b0;
                end else if (CE) begin
                    VALID_OUT <= w_v_in;
                    if (w_v_in) begin
                        DOUT <= w_res;
                        COUT <= w_c_out;
                        OVF  <= w_ovf;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccu_chain_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccu_chain_pipe
//  Purpose  : Directed self-checking bench for ccu_chain_pipe (16/8, LATENCY 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ccu_chain_pipe;

    localparam logic [1:0] c_add = 2'b00;
    localparam logic [1:0] c_sub = 2'b01;
    localparam logic [1:0] c_inc = 2'b10;
    localparam logic [1:0] c_dec = 2'b11;

    logic        CLK = 1'b0;
    logic        LSR;
    logic        CE;
    logic        VALID_IN;
    logic [1:0]  OP;
    logic [15:0] A;
    logic [15:0] B;
    logic        CIN;
    logic [15:0] DOUT;
    logic        COUT;
    logic        OVF;
    logic        VALID_OUT;

    int n_vec  = 0;
    int n_fail = 0;

    ccu_chain_pipe #(.WIDTH(16), .SEG_WIDTH(8)) dut (
        .CLK       (CLK),
        .LSR       (LSR),
        .CE        (CE),
        .VALID_IN  (VALID_IN),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .DOUT      (DOUT),
        .COUT      (COUT),
        .OVF       (OVF),
        .VALID_OUT (VALID_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        VALID_IN = v;
        OP       = op;
        A        = a;
        B        = b;
        CIN      = cin;
    endtask

    task automatic chk_v(input string tag, input logic exp_v,
                         input logic [15:0] exp_d);
        n_vec++;
        assert (VALID_OUT === exp_v) else begin
            n_fail++;
            $error("FAIL %s VALID_OUT got %b expected %b", tag, VALID_OUT, exp_v);
        end
        n_vec++;
        assert (DOUT === exp_d) else begin
            n_fail++;
            $error("FAIL %s DOUT got %h expected %h", tag, DOUT, exp_d);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_d,
                       input logic exp_c, input logic exp_o, input logic exp_v);
        chk_v(tag, exp_v, exp_d);
        n_vec++;
        assert (COUT === exp_c) else begin
            n_fail++;
            $error("FAIL %s COUT got %b expected %b", tag, COUT, exp_c);
        end
        n_vec++;
        assert (OVF === exp_o) else begin
            n_fail++;
            $error("FAIL %s OVF got %b expected %b", tag, OVF, exp_o);
        end
    endtask

    initial begin
        LSR = 1'b1;
        CE  = 1'b1;
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        step();
        chk("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        LSR = 1'b0;

        // Carry crosses the segment boundary; valid for exactly one cycle.
        drive(1'b1, c_add, 16'h00FF, 16'h0001, 1'b0);
        step();
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        chk_v("xseg_early", 1'b0, 16'h0000);
        step();
        chk("xseg", 16'h0100, 1'b0, 1'b0, 1'b1);
        step();
        chk("xseg_hold", 16'h0100, 1'b0, 1'b0, 1'b0);

        drive(1'b1, c_add, 16'h7FFF, 16'h0001, 1'b0);
        step();
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
`ifdef CCU_CHAIN_PIPE_SATURATE_EN
        chk("ovf", 16'h7FFF, 1'b0, 1'b1, 1'b1);
`else
        chk("ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
`endif

        // Back-to-back SUB with borrow out, then DEC.
        drive(1'b1, c_sub, 16'h0000, 16'h0001, 1'b0);
        step();
        drive(1'b1, c_dec, 16'h0100, 16'h5A5A, 1'b1);
        step();
        chk("sub_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        chk("dec", 16'h00FF, 1'b1, 1'b0, 1'b1);
        step();

        // Streaming with a 3-cycle stall after the first result.
        drive(1'b1, c_add, 16'h0001, 16'h0001, 1'b0);
        step();
        drive(1'b1, c_add, 16'h0002, 16'h0002, 1'b0);
        step();
        chk("stream0", 16'h0002, 1'b0, 1'b0, 1'b1);
        drive(1'b1, c_add, 16'h0003, 16'h0003, 1'b0);
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall", 16'h0002, 1'b0, 1'b0, 1'b1);
        end
        CE = 1'b1;
        step();
        chk("stream1", 16'h0004, 1'b0, 1'b0, 1'b1);
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        chk("stream2", 16'h0006, 1'b0, 1'b0, 1'b1);
        step();
        chk_v("stream_end", 1'b0, 16'h0006);

        // Reset while an operation is in flight discards it.
        drive(1'b1, c_add, 16'hFFFF, 16'h0001, 1'b0);
        step();
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        LSR = 1'b1;
        step();
        LSR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_flight", 16'h0000, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, c_add, 16'h1234, 16'h0001, 1'b0);
        step();
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        chk("post_rst", 16'h1235, 1'b0, 1'b0, 1'b1);

        // Reset coincident with a valid input drops the input.
        drive(1'b1, c_add, 16'h4000, 16'h0001, 1'b0);
        LSR = 1'b1;
        step();
        LSR = 1'b0;
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        chk("rst_vs_in0", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst_vs_in1", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Bubble pattern 1,0,1.
        drive(1'b1, c_add, 16'h0010, 16'h0010, 1'b0);
        step();
        drive(1'b0, c_sub, 16'h5555, 16'hAAAA, 1'b1);
        step();
        chk("bubble0", 16'h0020, 1'b0, 1'b0, 1'b1);
        drive(1'b1, c_inc, 16'hFFFF, 16'h1234, 1'b1);
        step();
        chk("bubble1", 16'h0020, 1'b0, 1'b0, 1'b0);
        drive(1'b0, c_add, 16'h0000, 16'h0000, 1'b0);
        step();
        chk("bubble2", 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        chk_v("bubble_end", 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
